// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the single-bus datapath: fetch in T0-T2,
// three-operand ALU execute in T3-T5, with memory wait, halt and retire counting.
//
// state | meaning
// IDLE  | waiting for start
// T0    | PC to MAR, PC+1 into Z
// T1    | Z to PC, memory read (held until mem ready)
// T2    | MDR to IR
// T3    | decode; Rb into Y for ALU ops
// T4    | Rc op Y into Z
// T5    | Z into Ra, retire
// HALT  | stopped until reset
module control_sequencer #(
  parameter int          CNT_W    = 16,
  parameter logic [4:0]  OPC_ADD  = 5'b00011,
  parameter logic [4:0]  OPC_SUB  = 5'b00100,
  parameter logic [4:0]  OPC_AND  = 5'b01001,
  parameter logic [4:0]  OPC_OR   = 5'b01010,
  parameter logic [4:0]  OPC_NOP  = 5'b11011,
  parameter logic [4:0]  OPC_HALT = 5'b11100
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_mem_ready,
  input  logic [31:0]      i_ir,
  output logic             o_pcout,
  output logic             o_zlowout,
  output logic             o_mdrout,
  output logic             o_rout,
  output logic             o_marin,
  output logic             o_pcin,
  output logic             o_mdrin,
  output logic             o_irin,
  output logic             o_yin,
  output logic             o_zin,
  output logic             o_rin,
  output logic             o_incpc,
  output logic             o_read,
  output logic             o_add,
  output logic             o_sub,
  output logic             o_and,
  output logic             o_or,
  output logic [3:0]       o_rsel,
  output logic [3:0]       o_present_state,
  output logic             o_illegal,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_instr_count
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_HALT = 4'd7
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_instr_count;

  logic [4:0] w_opc;
  logic [3:0] w_ra, w_rb, w_rc;
  logic       w_is_add, w_is_sub, w_is_and, w_is_or, w_is_alu;
  logic       w_is_nop, w_is_halt;
  logic       w_unused_ir;

  assign w_opc       = i_ir[31:27];
  assign w_ra        = i_ir[26:23];
  assign w_rb        = i_ir[22:19];
  assign w_rc        = i_ir[18:15];
  assign w_unused_ir = ^i_ir[14:0];

  assign w_is_add  = (w_opc == OPC_ADD);
  assign w_is_sub  = (w_opc == OPC_SUB);
  assign w_is_and  = (w_opc == OPC_AND);
  assign w_is_or   = (w_opc == OPC_OR);
  assign w_is_alu  = w_is_add | w_is_sub | w_is_and | w_is_or;
  assign w_is_nop  = (w_opc == OPC_NOP);
  assign w_is_halt = (w_opc == OPC_HALT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_instr_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) r_state <= S_T0;
        S_T0:   r_state <= S_T1;
        S_T1:   if (i_mem_ready) r_state <= S_T2;
        S_T2:   r_state <= S_T3;
        S_T3: begin
          if (w_is_alu) begin
            r_state <= S_T4;
          end else if (w_is_nop) begin
            r_instr_count <= r_instr_count + CNT_W'(1);
            r_state       <= S_T0;
          end else if (w_is_halt) begin
            r_instr_count <= r_instr_count + CNT_W'(1);
            r_state       <= S_HALT;
          end else begin
            r_state <= S_T0;
          end
        end
        S_T4:   r_state <= S_T5;
        S_T5: begin
          r_instr_count <= r_instr_count + CNT_W'(1);
          r_state       <= S_T0;
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // IR is only loaded at the end of T2, so T3-T5 strobes decode it combinationally.
  always_comb begin
    o_pcout   = 1'b0;
    o_zlowout = 1'b0;
    o_mdrout  = 1'b0;
    o_rout    = 1'b0;
    o_marin   = 1'b0;
    o_pcin    = 1'b0;
    o_mdrin   = 1'b0;
    o_irin    = 1'b0;
    o_yin     = 1'b0;
    o_zin     = 1'b0;
    o_rin     = 1'b0;
    o_incpc   = 1'b0;
    o_read    = 1'b0;
    o_add     = 1'b0;
    o_sub     = 1'b0;
    o_and     = 1'b0;
    o_or      = 1'b0;
    o_rsel    = 4'd0;
    o_illegal = 1'b0;
    o_halted  = 1'b0;
    case (r_state)
      S_T0: begin
        o_pcout = 1'b1;
        o_marin = 1'b1;
        o_incpc = 1'b1;
        o_zin   = 1'b1;
      end
      S_T1: begin
        o_zlowout = 1'b1;
        o_pcin    = 1'b1;
        o_read    = 1'b1;
        o_mdrin   = 1'b1;
      end
      S_T2: begin
        o_mdrout = 1'b1;
        o_irin   = 1'b1;
      end
      S_T3: begin
        if (w_is_alu) begin
          o_rout = 1'b1;
          o_yin  = 1'b1;
          o_rsel = w_rb;
        end else if (!w_is_nop && !w_is_halt) begin
          o_illegal = 1'b1;
        end
      end
      S_T4: begin
        o_rout = 1'b1;
        o_zin  = 1'b1;
        o_rsel = w_rc;
        o_add  = w_is_add;
        o_sub  = w_is_sub;
        o_and  = w_is_and;
        o_or   = w_is_or;
      end
      S_T5: begin
        o_zlowout = 1'b1;
        o_rin     = 1'b1;
        o_rsel    = w_ra;
      end
      S_HALT: o_halted = 1'b1;
      default: ;
    endcase
  end

  assign o_present_state = r_state;
  assign o_instr_count   = r_instr_count;

endmodule
